// File: rtl/axis_mul_pkg.sv
// Shared definitions for the AXI-Stream constant multiplier slice.
// Contents:
//   DEF_*         default widths used as parameter defaults
//   prod_width()  width of a full-precision data x constant product
//   skid_state_t  occupancy of a one-entry skid buffer
package axis_mul_pkg;

  localparam int DEF_DATA_W      = 32;
  localparam int DEF_CONST_W     = 8;
  localparam int DEF_FRAME_CNT_W = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } skid_state_t;

  function automatic int prod_width(input int data_w, input int const_w);
    return data_w + const_w;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// One-entry skid buffer with a registered upstream ready.
// Ports:
//   clk, aresetn      clock, synchronous active-low reset
//   up_valid/up_ready upstream handshake (up_ready is a flop)
//   up_data           upstream payload
//   dn_valid/dn_ready downstream handshake (dn_ready may be combinational)
//   dn_data           downstream payload (skid entry when full, else up_data)
module axis_skid_buffer
  import axis_mul_pkg::*;
#(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic                 up_valid,
  output logic                 up_ready,
  input  logic [PAYLOAD_W-1:0] up_data,
  output logic                 dn_valid,
  input  logic                 dn_ready,
  output logic [PAYLOAD_W-1:0] dn_data
);

  skid_state_t          state;
  logic [PAYLOAD_W-1:0] skid_data;
  logic                 accept;

  // up_ready is only high while the entry is empty, so an accepted beat
  // always has somewhere to go: straight through, or into the entry.
  assign accept   = up_valid && up_ready;
  assign dn_valid = (state == FULL) || accept;
  assign dn_data  = (state == FULL) ? skid_data : up_data;

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state    <= EMPTY;
      up_ready <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept && !dn_ready) begin
            state    <= FULL;
            up_ready <= 1'b0;
          end else begin
            up_ready <= 1'b1;
          end
        end
        FULL: begin
          if (dn_ready) begin
            state    <= EMPTY;
            up_ready <= 1'b1;
          end else begin
            up_ready <= 1'b0;
          end
        end
        default: begin
          state    <= EMPTY;
          up_ready <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == EMPTY && accept && !dn_ready) begin
      skid_data <= up_data;
    end
  end

endmodule

// File: rtl/axis_const_multiplier.sv
// AXI-Stream stage that multiplies each beat by an 8-bit constant, or
// passes it through when disabled. Skid-buffered input, 2-stage pipeline.
// Optional macro AXIS_CONST_MULTIPLIER_SATURATE_EN: saturate on overflow
// instead of truncating and expose a sticky sat_flag output.
// Ports:
//   s00_axis_aclk, s00_axis_aresetn  clock, synchronous active-low reset
//   mul_en, mul_mult_const           sampled with each accepted beat
//   s00_axis_*                       input stream (tready registered)
//   m00_axis_*                       output stream
//   frame_count                      tlast beats delivered, wraps
//   sat_flag                         (macro only) sticky overflow flag
module axis_const_multiplier
  import axis_mul_pkg::*;
#(
  parameter int C_S00_AXIS_TDATA_WIDTH = DEF_DATA_W,
  parameter int C_M00_AXIS_TDATA_WIDTH = DEF_DATA_W,
  parameter int C_CONST_WIDTH          = DEF_CONST_W,
  parameter int C_FRAME_CNT_WIDTH      = DEF_FRAME_CNT_W
) (
  input  logic                                s00_axis_aclk,
  input  logic                                s00_axis_aresetn,
  input  logic                                mul_en,
  input  logic [C_CONST_WIDTH-1:0]            mul_mult_const,
  input  logic                                s00_axis_tvalid,
  output logic                                s00_axis_tready,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
  input  logic                                s00_axis_tlast,
  output logic                                m00_axis_tvalid,
  input  logic                                m00_axis_tready,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                                m00_axis_tlast,
  output logic [C_FRAME_CNT_WIDTH-1:0]        frame_count
`ifdef AXIS_CONST_MULTIPLIER_SATURATE_EN
  ,
  output logic                                sat_flag
`endif
);

  localparam int DATA_W    = C_S00_AXIS_TDATA_WIDTH;
  localparam int STRB_W    = DATA_W / 8;
  localparam int CONST_W   = C_CONST_WIDTH;
  localparam int PROD_W    = prod_width(DATA_W, CONST_W);
  localparam int PAYLOAD_W = DATA_W + STRB_W + 1 + 1 + CONST_W;

  // Result of one beat: pass-through, or the product reduced to DATA_W.
  function automatic logic [DATA_W-1:0] scale(input logic [DATA_W-1:0]  d,
                                              input logic               en,
                                              input logic [CONST_W-1:0] c);
`ifdef AXIS_CONST_MULTIPLIER_SATURATE_EN
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(d) * PROD_W'(c);
    if (!en) return d;
    if (|prod[PROD_W-1:DATA_W]) return '1;
    return prod[DATA_W-1:0];
`else
    if (!en) return d;
    return DATA_W'(PROD_W'(d) * PROD_W'(c));
`endif
  endfunction

`ifdef AXIS_CONST_MULTIPLIER_SATURATE_EN
  function automatic logic overflow(input logic [DATA_W-1:0]  d,
                                    input logic               en,
                                    input logic [CONST_W-1:0] c);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(d) * PROD_W'(c);
    return en && (|prod[PROD_W-1:DATA_W]);
  endfunction
`endif

  logic                 ce;
  logic                 dn_valid;
  logic [PAYLOAD_W-1:0] up_payload;
  logic [PAYLOAD_W-1:0] dn_payload;

  // The whole pipeline moves as one; it only freezes while a beat sits
  // unaccepted on the master port.
  assign ce         = !m00_axis_tvalid || m00_axis_tready;
  assign up_payload = {s00_axis_tdata, s00_axis_tstrb, s00_axis_tlast,
                       mul_en, mul_mult_const};

  axis_skid_buffer #(
    .PAYLOAD_W (PAYLOAD_W)
  ) u_skid (
    .clk      (s00_axis_aclk),
    .aresetn  (s00_axis_aresetn),
    .up_valid (s00_axis_tvalid),
    .up_ready (s00_axis_tready),
    .up_data  (up_payload),
    .dn_valid (dn_valid),
    .dn_ready (ce),
    .dn_data  (dn_payload)
  );

  // ---- stage 1: operand, sideband and control sampled with the beat ----
  logic                 vld_p1;
  logic [DATA_W-1:0]    data_p1;
  logic [STRB_W-1:0]    strb_p1;
  logic                 last_p1;
  logic                 en_p1;
  logic [CONST_W-1:0]   const_p1;

  always_ff @(posedge s00_axis_aclk) begin
    if (ce) begin
      {data_p1, strb_p1, last_p1, en_p1, const_p1} <= dn_payload;
    end
  end

  // ---- stage 2: multiply and register onto the master port ----
  always_ff @(posedge s00_axis_aclk) begin
    if (!s00_axis_aresetn) begin
      vld_p1          <= 1'b0;
      m00_axis_tvalid <= 1'b0;
      m00_axis_tdata  <= '0;
      m00_axis_tstrb  <= '0;
      m00_axis_tlast  <= 1'b0;
      frame_count     <= '0;
    end else begin
      if (ce) begin
        vld_p1          <= dn_valid;
        m00_axis_tvalid <= vld_p1;
        m00_axis_tdata  <= scale(data_p1, en_p1, const_p1);
        m00_axis_tstrb  <= strb_p1;
        m00_axis_tlast  <= last_p1;
      end
      if (m00_axis_tvalid && m00_axis_tready && m00_axis_tlast) begin
        frame_count <= frame_count + C_FRAME_CNT_WIDTH'(1);
      end
    end
  end

`ifdef AXIS_CONST_MULTIPLIER_SATURATE_EN
  always_ff @(posedge s00_axis_aclk) begin
    if (!s00_axis_aresetn) begin
      sat_flag <= 1'b0;
    end else if (ce && vld_p1 && overflow(data_p1, en_p1, const_p1)) begin
      sat_flag <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_axis_const_multiplier.sv
module tb_axis_const_multiplier;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        mul_en = 1'b0;
  logic [7:0]  mul_mult_const = 8'd0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [31:0] s_tdata = 32'd0;
  logic [3:0]  s_tstrb = 4'd0;
  logic        s_tlast = 1'b0;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic [31:0] m_tdata;
  logic [3:0]  m_tstrb;
  logic        m_tlast;
  logic [15:0] frame_count;
`ifdef AXIS_CONST_MULTIPLIER_SATURATE_EN
  logic        sat_flag;
`endif

  axis_const_multiplier dut (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (aresetn),
    .mul_en           (mul_en),
    .mul_mult_const   (mul_mult_const),
    .s00_axis_tvalid  (s_tvalid),
    .s00_axis_tready  (s_tready),
    .s00_axis_tdata   (s_tdata),
    .s00_axis_tstrb   (s_tstrb),
    .s00_axis_tlast   (s_tlast),
    .m00_axis_tvalid  (m_tvalid),
    .m00_axis_tready  (m_tready),
    .m00_axis_tdata   (m_tdata),
    .m00_axis_tstrb   (m_tstrb),
    .m00_axis_tlast   (m_tlast),
    .frame_count      (frame_count)
`ifdef AXIS_CONST_MULTIPLIER_SATURATE_EN
    ,
    .sat_flag         (sat_flag)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
    int          acc_cyc;
    bit          chk_lat;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   frames_seen = 0;
  bit   exp_sat = 1'b0;
  bit   chk_lat = 1'b0;
  int   rdy_mode = 0;  // 0 always ready, 1 toggle, 2 random, 3 never

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: full-precision product, then truncate or saturate.
  function automatic logic [31:0] model(input logic [31:0] d, input logic en,
                                        input logic [7:0] c);
    logic [63:0] p;
    p = 64'(d) * 64'(c);
    if (!en) return d;
`ifdef AXIS_CONST_MULTIPLIER_SATURATE_EN
    if (p[63:32] != 32'd0) return 32'hFFFF_FFFF;
`endif
    return p[31:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Downstream ready pattern.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = ~m_tready;
      2:       m_tready = 1'($urandom_range(0, 1));
      default: m_tready = 1'b0;
    endcase
  end

  // Monitor: pops the scoreboard on every master handshake.
  bit          stall_prev = 1'b0;
  logic [36:0] held = '0;
  always @(negedge clk) begin
    exp_t e;
    if (aresetn) begin
      if (stall_prev)
        check("stall_hold", {m_tvalid, m_tdata, m_tstrb, m_tlast}, {1'b1, held});
      if (m_tvalid && m_tready) begin
        if (sbq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got data 0x%0h, expected no beat", m_tdata);
        end else begin
          e = sbq.pop_front();
          check("tdata", 64'(m_tdata), 64'(e.data));
          check("tstrb", 64'(m_tstrb), 64'(e.strb));
          check("tlast", 64'(m_tlast), 64'(e.last));
          if (e.chk_lat) check("latency", 64'(cyc - e.acc_cyc), 64'd2);
          if (e.last) begin
            check("frame_count_pre", 64'(frame_count), 64'(frames_seen[15:0]));
            frames_seen++;
          end
        end
      end
      stall_prev = m_tvalid && !m_tready;
      held = {m_tdata, m_tstrb, m_tlast};
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the handshake.
  task automatic send(input logic [31:0] d, input logic [3:0] st, input logic l);
    exp_t e;
    int   waited;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tstrb  = st;
    s_tlast  = l;
    waited   = 0;
    @(negedge clk);
    while (!s_tready) begin
      waited++;
      if (waited > 500) begin
        $display("FAIL send_timeout: s00_axis_tready stuck at 0, expected 1");
        n_checks++;
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "handshake timeout");
      end
      @(posedge clk);
      #1;
      @(negedge clk);
    end
    e.data    = model(d, mul_en, mul_mult_const);
    e.strb    = st;
    e.last    = l;
    e.acc_cyc = cyc;
    e.chk_lat = chk_lat;
    if (mul_en && ((64'(d) * 64'(mul_mult_const)) >> 32) != 64'd0) exp_sat = 1'b1;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (sbq.size() != 0 && waited < 1000) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check("drain_empty", 64'(sbq.size()), 64'd0);
    idle(3);
  endtask

  task automatic check_sat();
`ifdef AXIS_CONST_MULTIPLIER_SATURATE_EN
    check("sat_flag", 64'(sat_flag), 64'(exp_sat));
`endif
  endtask

  initial begin
    // Reset state.
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_tready", 64'(s_tready), 64'd0);
    check("rst_frame", 64'(frame_count), 64'd0);
    check("rst_tdata", {27'd0, m_tdata, m_tstrb, m_tlast}, 64'd0);
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    @(negedge clk);
    check("tready_pre", 64'(s_tready), 64'd0);
    @(negedge clk);
    check("tready_post", 64'(s_tready), 64'd1);
    @(posedge clk);
    #1;

    // Basic multiply with latency check.
    mul_en = 1'b1;
    mul_mult_const = 8'd3;
    chk_lat = 1'b1;
    send(32'd1, 4'hF, 1'b0);
    send(32'd2, 4'hF, 1'b0);
    send(32'h10, 4'hF, 1'b1);
    idle(1);
    send(32'd7, 4'h3, 1'b0);
    drain();
    chk_lat = 1'b0;
    check("frame_count_1", 64'(frame_count), 64'd1);

    // Pass-through.
    mul_en = 1'b0;
    mul_mult_const = 8'd5;
    send(32'hDEAD_BEEF, 4'hF, 1'b0);
    drain();

    // Truncation / saturation edge.
    mul_en = 1'b1;
    mul_mult_const = 8'hFF;
    send(32'h0100_0000, 4'hF, 1'b0);
    send(32'h0200_0000, 4'hF, 1'b0);
    mul_mult_const = 8'h00;
    send(32'h1234_5678, 4'hF, 1'b0);
    drain();
    check_sat();

    // Continuous valid with alternating ready.
    rdy_mode = 1;
    mul_mult_const = 8'd2;
    for (int i = 0; i < 64; i++) send(32'(i + 100), 4'hF, i == 63);
    rdy_mode = 0;
    drain();

    // Constant change with beats in flight.
    rdy_mode = 3;
    idle(2);
    mul_mult_const = 8'd2;
    send(32'd10, 4'hF, 1'b0);
    send(32'd11, 4'hF, 1'b0);
    mul_mult_const = 8'd7;
    send(32'd12, 4'hF, 1'b0);
    idle(3);
    rdy_mode = 0;
    send(32'd13, 4'hF, 1'b1);
    drain();

    // Randomized traffic.
    rdy_mode = 2;
    for (int i = 0; i < 200; i++) begin
      mul_en = 1'($urandom_range(0, 3) != 0);
      mul_mult_const = 8'($urandom);
      send($urandom, 4'($urandom), $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rdy_mode = 0;
    drain();
    check_sat();
    check("frame_count_rand", 64'(frame_count), 64'(frames_seen[15:0]));

    // Reset mid-frame with beats in flight.
    rdy_mode = 3;
    idle(2);
    mul_en = 1'b1;
    mul_mult_const = 8'd9;
    send(32'd50, 4'hF, 1'b0);
    send(32'd51, 4'hF, 1'b0);
    s_tvalid = 1'b0;
    aresetn = 1'b0;
    sbq.delete();
    frames_seen = 0;
    exp_sat = 1'b0;
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    rdy_mode = 0;
    @(negedge clk);
    check("rst2_tvalid", 64'(m_tvalid), 64'd0);
    check("rst2_frame", 64'(frame_count), 64'd0);
    check_sat();
    @(posedge clk);
    #1;
    mul_mult_const = 8'd4;
    send(32'd1, 4'hF, 1'b0);
    send(32'd2, 4'hF, 1'b0);
    send(32'd3, 4'hF, 1'b1);
    drain();
    check("frame_count_after_rst", 64'(frame_count), 64'd1);
    check("final_queue", 64'(sbq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks + 1, n_fail + 1);
    $fatal(1, "timeout");
  end

endmodule
